// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage between execute and write-back.
// Drives a req/ack data bus, aligns lanes and extends load data.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_IE_valid,
    input  logic [DATA_WIDTH-1:0]     i_IE_result,
    input  logic [DATA_WIDTH-1:0]     i_IE_data_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_IE_rd_addr,
    input  logic                      i_ctrl_reg_write,
    input  logic                      i_ctrl_mem_read,
    input  logic                      i_ctrl_mem_write,
    input  logic [1:0]                i_ctrl_mem_size,
    input  logic                      i_ctrl_mem_unsigned,
    output logic                      o_IM_stall,
    output logic                      o_dmem_req,
    output logic                      o_dmem_we,
    output logic [DATA_WIDTH-1:0]     o_dmem_addr,
    output logic [DATA_WIDTH-1:0]     o_dmem_wdata,
    output logic [3:0]                o_dmem_be,
    input  logic                      i_dmem_ack,
    input  logic [DATA_WIDTH-1:0]     i_dmem_rdata,
    output logic                      o_IM_valid,
    output logic [DATA_WIDTH-1:0]     o_IM_result,
    output logic [REG_ADDR_WIDTH-1:0] o_IM_rd_addr,
    output logic                      o_IM_reg_write,
    output logic                      o_IM_misaligned
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                    state_q;

    // Pending transaction context, captured at accept.
    logic [DATA_WIDTH-1:0]     addr_q;
    logic [1:0]                size_q;
    logic                      unsigned_q;
    logic                      load_q;
    logic                      pend_rw_q;
    logic [REG_ADDR_WIDTH-1:0] pend_rd_q;

    // Bus-facing registers, stable for the whole WAIT period.
    logic                      we_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [3:0]                be_q;

    // Write-back registers.
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      reg_write_q;
    logic                      misaligned_q;

    // Decoded view of the incoming instruction.
    logic                      is_load;
    logic                      is_store;
    logic                      is_mem;
    logic                      sz_byte;
    logic                      sz_half;
    logic [DATA_WIDTH-1:0]     wdata_d;
    logic [3:0]                be_d;
    logic                      misaligned_d;

    // Extended load value for the pending access.
    logic [7:0]                lane_byte;
    logic [15:0]               lane_half;
    logic [DATA_WIDTH-1:0]     load_data_d;

    // Decode the op: read wins over write; build store lanes and alignment.
    always_comb begin
        is_load  = i_ctrl_mem_read;
        is_store = i_ctrl_mem_write & ~i_ctrl_mem_read;
        is_mem   = is_load | is_store;
        sz_byte  = (i_ctrl_mem_size == 2'b00);
        sz_half  = (i_ctrl_mem_size == 2'b01);
        wdata_d      = i_IE_data_write;
        be_d         = 4'b1111;
        misaligned_d = 1'b0;
        unique case (1'b1)
            sz_byte: begin
                wdata_d      = {4{i_IE_data_write[7:0]}};
                be_d         = 4'b0001 << i_IE_result[1:0];
                misaligned_d = 1'b0;
            end
            sz_half: begin
                wdata_d      = {2{i_IE_data_write[15:0]}};
                be_d         = i_IE_result[1] ? 4'b1100 : 4'b0011;
                misaligned_d = i_IE_result[0];
            end
            default: begin
                wdata_d      = i_IE_data_write;
                be_d         = 4'b1111;
                misaligned_d = |i_IE_result[1:0];
            end
        endcase
        if (!is_store) begin
            be_d = 4'b0000;
        end
        misaligned_d = misaligned_d & is_mem;
    end

    // Pick the addressed lane from the read word and extend it.
    always_comb begin
        lane_byte   = i_dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_half   = addr_q[1] ? i_dmem_rdata[31:16]
                                : i_dmem_rdata[15:0];
        load_data_d = i_dmem_rdata;
        unique case (1'b1)
            (size_q == 2'b00): begin
                load_data_d = {{(DATA_WIDTH-8){lane_byte[7] & ~unsigned_q}},
                               lane_byte};
            end
            (size_q == 2'b01): begin
                load_data_d = {{(DATA_WIDTH-16){lane_half[15] & ~unsigned_q}},
                               lane_half};
            end
            default: begin
                load_data_d = i_dmem_rdata;
            end
        endcase
    end

    // Stage FSM: accept in IDLE, hold the bus in WAIT until ack, retire.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            load_q       <= 1'b0;
            pend_rw_q    <= 1'b0;
            pend_rd_q    <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= 4'b0000;
            valid_q      <= 1'b0;
            result_q     <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_IE_valid) begin
                        if (!is_mem) begin
                            valid_q      <= 1'b1;
                            result_q     <= i_IE_result;
                            rd_q         <= i_IE_rd_addr;
                            reg_write_q  <= i_ctrl_reg_write;
                            misaligned_q <= 1'b0;
                        end else if (misaligned_d) begin
                            valid_q      <= 1'b1;
                            result_q     <= i_IE_result;
                            rd_q         <= i_IE_rd_addr;
                            reg_write_q  <= 1'b0;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q    <= WAIT;
                            addr_q     <= i_IE_result;
                            size_q     <= i_ctrl_mem_size;
                            unsigned_q <= i_ctrl_mem_unsigned;
                            load_q     <= is_load;
                            pend_rw_q  <= i_ctrl_reg_write;
                            pend_rd_q  <= i_IE_rd_addr;
                            we_q       <= is_store;
                            wdata_q    <= wdata_d;
                            be_q       <= be_d;
                        end
                    end
                end
                WAIT: begin
                    if (i_dmem_ack) begin
                        state_q      <= IDLE;
                        valid_q      <= 1'b1;
                        rd_q         <= pend_rd_q;
                        misaligned_q <= 1'b0;
                        if (load_q) begin
                            result_q    <= load_data_d;
                            reg_write_q <= pend_rw_q;
                        end else begin
                            result_q    <= addr_q;
                            reg_write_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request and stall follow the state directly so reset drops them at once.
    assign o_IM_stall      = (state_q == WAIT);
    assign o_dmem_req      = (state_q == WAIT);
    assign o_dmem_we       = we_q;
    assign o_dmem_addr     = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign o_dmem_wdata    = wdata_q;
    assign o_dmem_be       = be_q;
    assign o_IM_valid      = valid_q;
    assign o_IM_result     = result_q;
    assign o_IM_rd_addr    = rd_q;
    assign o_IM_reg_write  = reg_write_q;
    assign o_IM_misaligned = misaligned_q;

endmodule
